// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, condition, flag and state definitions for the ALU issue path
package alu_pkg;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_MOVI = 4'b0111;
    localparam logic [3:0] OP_LSR  = 4'b1000;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_ROR  = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes 1100-1111 are reserved.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// rtl/alu_cond_eval.sv - ARM-style condition code evaluation against NZCV flags
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLG_N];
    assign z = flags_i[FLG_Z];
    assign c = flags_i[FLG_C];
    assign v = flags_i[FLG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - one-at-a-time issue controller for the combinational ALU
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [3:0]    in_cond,
    input  logic          in_s,
    input  logic [DW-1:0] in_reg1,
    input  logic [DW-1:0] in_reg2,
    input  logic [15:0]   in_iv,
    output logic [3:0]    alu_opcode,
    output logic [DW-1:0] alu_reg1,
    output logic [DW-1:0] alu_reg2,
    output logic [15:0]   alu_iv,
    output logic          alu_s,
    output logic [3:0]    alu_flag,
    input  logic [DW-1:0] alu_result,
    input  logic [3:0]    alu_new_flag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_wr,
    output logic          out_illegal,
    output logic [3:0]    flags
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    op_q;
    logic [3:0]    cond_q;
    logic          s_q;
    logic [DW-1:0] reg1_q;
    logic [DW-1:0] reg2_q;
    logic [15:0]   iv_q;
    logic [3:0]    flags_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] out_result_q;
    logic          out_wr_q;
    logic          out_illegal_q;

    logic          cond_pass;
    logic          illegal;
    logic [3:0]    flags_d;
    logic [DW-1:0] out_result_d;
    logic          out_wr_d;

    alu_cond_eval u_cond_eval (
        .cond_i  (cond_q),
        .flags_i (flags_q),
        .pass_o  (cond_pass)
    );

    assign illegal = is_illegal(op_q);

    // Writeback view of the instruction, captured on the last EXEC cycle.
    always_comb begin
        flags_d      = flags_q;
        out_result_d = '0;
        out_wr_d     = 1'b0;
        if (cond_pass && !illegal) begin
            out_result_d = alu_result;
            if (op_q == OP_CMP) begin
                flags_d = alu_new_flag;
            end else begin
                out_wr_d = 1'b1;
                if (s_q) begin
                    flags_d = alu_new_flag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            cond_q        <= '0;
            s_q           <= 1'b0;
            reg1_q        <= '0;
            reg2_q        <= '0;
            iv_q          <= '0;
            flags_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_wr_q      <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_opcode;
                        cond_q     <= in_cond;
                        s_q        <= in_s;
                        reg1_q     <= in_reg1;
                        reg2_q     <= in_reg2;
                        iv_q       <= in_iv;
                        cnt_q      <= (in_opcode == OP_MUL) ? CW'(MUL_LAT - 1) : '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Cond-fail and illegal ops still run the full count so latency depends only on opcode.
                    if (cnt_q == '0) begin
                        flags_q       <= flags_d;
                        out_result_q  <= out_result_d;
                        out_wr_q      <= out_wr_d;
                        out_illegal_q <= illegal;
                        out_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign alu_opcode  = op_q;
    assign alu_reg1    = reg1_q;
    assign alu_reg2    = reg2_q;
    assign alu_iv      = iv_q;
    assign alu_s       = s_q;
    assign alu_flag    = flags_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_wr      = out_wr_q;
    assign out_illegal = out_illegal_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    localparam int DW      = 32;
    localparam int MUL_LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [3:0]    in_cond;
    logic          in_s;
    logic [DW-1:0] in_reg1;
    logic [DW-1:0] in_reg2;
    logic [15:0]   in_iv;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_reg1;
    logic [DW-1:0] alu_reg2;
    logic [15:0]   alu_iv;
    logic          alu_s;
    logic [3:0]    alu_flag;
    logic [DW-1:0] alu_result;
    logic [3:0]    alu_new_flag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_wr;
    logic          out_illegal;
    logic [3:0]    flags;

    logic [3:0]    nf;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_cond      (in_cond),
        .in_s         (in_s),
        .in_reg1      (in_reg1),
        .in_reg2      (in_reg2),
        .in_iv        (in_iv),
        .alu_opcode   (alu_opcode),
        .alu_reg1     (alu_reg1),
        .alu_reg2     (alu_reg2),
        .alu_iv       (alu_iv),
        .alu_s        (alu_s),
        .alu_flag     (alu_flag),
        .alu_result   (alu_result),
        .alu_new_flag (alu_new_flag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_wr       (out_wr),
        .out_illegal  (out_illegal),
        .flags        (flags)
    );

    // Stand-in for the external ALU; flags are chosen per step by the bench.
    always_comb begin
        case (alu_opcode)
            4'b0001: alu_result = alu_reg1 + alu_reg2;
            4'b0010: alu_result = alu_reg1 - alu_reg2;
            4'b0011: alu_result = alu_reg1 * alu_reg2;
            4'b0110: alu_result = alu_reg1 ^ alu_reg2;
            4'b1011: alu_result = alu_reg1 - alu_reg2;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_new_flag = nf;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] f);
        chk("idle_ready", 32'(in_ready), 32'd1);
        in_opcode = op;
        in_cond   = cond;
        in_s      = s;
        in_reg1   = r1;
        in_reg2   = r2;
        nf        = f;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_reg1   = 32'h0;
        in_reg2   = 32'h0;
    endtask

    task automatic wait_done(input int lat, input logic [3:0] op, input logic [31:0] r1);
        for (int i = 1; i <= lat; i++) begin
            chk("exec_valid", 32'(out_valid), 32'd0);
            chk("exec_ready", 32'(in_ready), 32'd0);
            chk("exec_op", 32'(alu_opcode), 32'(op));
            chk("exec_reg1", alu_reg1, r1);
            @(negedge clk);
        end
        chk("done_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        chk("retire_valid", 32'(out_valid), 32'd0);
        chk("retire_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_cond = '0; in_s = 1'b0;
        in_reg1 = '0; in_reg2 = '0; in_iv = '0; out_ready = 1'b1; nf = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_wr", 32'(out_wr), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_alu_op", 32'(alu_opcode), 32'd0);
        chk("rst_alu_reg1", alu_reg1, 32'd0);

        // 1: ADD AL s=1
        in_iv = 16'h1234;
        issue(4'b0001, 4'hE, 1'b1, 32'd5, 32'd7, 4'b0000);
        chk("t1_alu_iv", 32'(alu_iv), 32'h1234);
        chk("t1_alu_s", 32'(alu_s), 32'd1);
        chk("t1_alu_reg2", alu_reg2, 32'd7);
        wait_done(1, 4'b0001, 32'd5);
        chk("t1_result", out_result, 32'd12);
        chk("t1_wr", 32'(out_wr), 32'd1);
        chk("t1_flags", 32'(flags), 32'h0);
        retire();

        // 2: SUB sets Z|C, then XOR NE fails
        issue(4'b0010, 4'hE, 1'b1, 32'd3, 32'd3, 4'b0110);
        wait_done(1, 4'b0010, 32'd3);
        chk("t2_sub_result", out_result, 32'd0);
        chk("t2_sub_wr", 32'(out_wr), 32'd1);
        chk("t2_sub_flags", 32'(flags), 32'h6);
        retire();
        issue(4'b0110, 4'h1, 1'b1, 32'hF0, 32'h0F, 4'b1111);
        chk("t2_alu_flag", 32'(alu_flag), 32'h6);
        wait_done(1, 4'b0110, 32'hF0);
        chk("t2_xor_wr", 32'(out_wr), 32'd0);
        chk("t2_xor_result", out_result, 32'd0);
        chk("t2_xor_flags", 32'(flags), 32'h6);
        retire();

        // 3: MUL takes MUL_LAT cycles
        issue(4'b0011, 4'hE, 1'b0, 32'd6, 32'd7, 4'b0000);
        wait_done(MUL_LAT, 4'b0011, 32'd6);
        chk("t3_result", out_result, 32'd42);
        chk("t3_wr", 32'(out_wr), 32'd1);
        chk("t3_flags", 32'(flags), 32'h6);
        retire();

        // 4: CMP s=0 still writes flags; writeback stalled
        out_ready = 1'b0;
        issue(4'b1011, 4'hE, 1'b0, 32'd1, 32'd2, 4'b1000);
        wait_done(1, 4'b1011, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_result", out_result, 32'hFFFF_FFFF);
            chk("t4_hold_wr", 32'(out_wr), 32'd0);
            chk("t4_hold_flags", 32'(flags), 32'h8);
            chk("t4_hold_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        retire();

        // LT passes with N=1,V=0; s=0 leaves flags
        issue(4'b0001, 4'hB, 1'b0, 32'd2, 32'd3, 4'b0001);
        wait_done(1, 4'b0001, 32'd2);
        chk("lt_result", out_result, 32'd5);
        chk("lt_wr", 32'(out_wr), 32'd1);
        chk("lt_flags", 32'(flags), 32'h8);
        retire();

        // 5: reserved opcode
        issue(4'b1100, 4'hE, 1'b1, 32'd9, 32'd9, 4'b0101);
        wait_done(1, 4'b1100, 32'd9);
        chk("t5_illegal", 32'(out_illegal), 32'd1);
        chk("t5_wr", 32'(out_wr), 32'd0);
        chk("t5_result", out_result, 32'd0);
        chk("t5_flags", 32'(flags), 32'h8);
        retire();

        // 6: reset in cycle 2 of a MUL
        issue(4'b0011, 4'hE, 1'b1, 32'd3, 32'd3, 4'b1111);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ready", 32'(in_ready), 32'd1);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_flags", 32'(flags), 32'h0);
        chk("t6_alu_op", 32'(alu_opcode), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_ghost", 32'(out_valid), 32'd0);
        end
        issue(4'b0001, 4'hE, 1'b1, 32'd1, 32'd1, 4'b0000);
        wait_done(1, 4'b0001, 32'd1);
        chk("t6_result", out_result, 32'd2);
        chk("t6_wr", 32'(out_wr), 32'd1);
        chk("t6_illegal", 32'(out_illegal), 32'd0);
        retire();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
